clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Programmable clock-divider controller. Generates a divided clock (clk_out) with runtime-configurable
//  high/low phase lengths. Ratio changes are accepted through a valid/ready config port and applied
//  only at a period boundary, so clk_out never glitches. Sits between the register/config logic and
//  every divided-clock consumer. Supersedes fixed-ratio dividers (default config = divide-by-3, 2 high / 1 low).
// PARAMETERS
//  CW        8   width of the phase counters and cfg_high/cfg_low
//  DEF_HIGH  2   high-phase length (clk cycles) loaded at reset
//  DEF_LOW   1   low-phase length (clk cycles) loaded at reset
// PORTS
//  clk          in   1    system clock; all logic on posedge
//  rst_n        in   1    synchronous reset, active low
//  en           in   1    run request; level-sensitive
//  cfg_valid    in   1    new ratio offered
//  cfg_ready    out  1    controller can take a new ratio
//  cfg_high     in   CW   requested high-phase length, must be >0
//  cfg_low      in   CW   requested low-phase length, must be >0
//  clk_out      out  1    divided clock, registered
//  busy         out  1    1 when state != STOP
//  period_done  out  1    1-cycle pulse on the last cycle of each LOW phase
//  cfg_err      out  1    1-cycle pulse: a zero-length config was rejected
//  period_cnt   out  16   completed-period counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=STOP, clk_out=0, busy=0, period_done=0, cfg_err=0, cfg_ready=1,
//    active {H,L}={DEF_HIGH,DEF_LOW}, pending cleared, phase counter=0, period_cnt=0. Reset overrides everything.
//  - FSM: STOP -> HIGH when en=1. HIGH -> LOW after H cycles. LOW -> HIGH after L cycles if en=1, else LOW -> STOP.
//  - Latency: en sampled 1 at edge k in STOP -> clk_out=1 from edge k onward. clk_out=1 for exactly H cycles,
//    then 0 for exactly L cycles. Period = H+L.
//  - en deassert mid-period: the current period finishes (HIGH and LOW both complete); stop only at the boundary.
//    In STOP, clk_out=0.
//  - Config handshake: transfer when cfg_valid&cfg_ready. If cfg_high==0 or cfg_low==0: reject, cfg_err pulses
//    the next cycle, pending unchanged. Otherwise write the pending register and drop cfg_ready to 0.
//  - Apply: a pending config loads into {H,L} at the next period boundary (last LOW cycle -> HIGH/STOP).
//    In STOP it loads on the cycle after acceptance. cfg_ready returns to 1 the cycle after the load.
//    A config accepted on a boundary cycle applies at the following boundary.
//  - Counting: the phase counter compares against H-1 / L-1 in CW bits. Max phase = 2^CW-1, no wrap inside a phase.
//    Values must be nonzero, so H=1,L=1 gives divide-by-2.
//  - period_done: asserted on the final LOW cycle of every completed period, including the last before STOP.
//  - cfg_valid held high while cfg_ready=0: ignored, no side effects.
// CONFIGURATION
//  CLK_DIV_CTRL_CNT_EN defined: period_cnt increments by 1 on each period_done, wraps 16'hFFFF->0, reset to 0.
//  Not defined: period_cnt tied to 16'h0 and no counter logic is synthesized. All other behaviour is identical.
// TESTING
//  1 Reset, en=1, no config -> clk_out pattern 1,1,0 repeating; period_done every 3rd cycle; busy=1.
//  2 Running 2/1, mid-HIGH accept {H=3,L=3} -> the current 2/1 period completes, then 1,1,1,0,0,0;
//    cfg_ready=0 until the cycle after the load.
//  3 cfg_high=0, cfg_low=4 offered -> cfg_err pulses once, cfg_ready stays 1, ratio unchanged.
//  4 Deassert en on the first HIGH cycle of a 3/3 ratio -> full 3 high + 3 low, period_done, then STOP with clk_out=0, busy=0.
//  5 rst_n=0 mid-LOW with a config pending -> next cycle clk_out=0, state STOP, pending dropped, cfg_ready=1, ratio 2/1.
//  6 CLK_DIV_CTRL_CNT_EN set, H=1,L=1, 65537 periods -> period_cnt=1 after wrap. Macro unset -> period_cnt=0 throughout.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: clk_out high for H cycles, low for L cycles, ratio changes only at period boundaries.
// Latency: en sampled high in STOP gives clk_out=1 from that edge; accepted config applies at the next boundary.
// Backpressure: cfg_ready drops while a ratio is pending and returns the cycle after it loads. Optional macro CLK_DIV_CTRL_CNT_EN adds period_cnt.
module clk_div_ctrl #(
  parameter int CW       = 8,
  parameter int DEF_HIGH = 2,
  parameter int DEF_LOW  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_high,
  input  logic [CW-1:0] cfg_low,
  output logic          clk_out,
  output logic          busy,
  output logic          period_done,
  output logic          cfg_err,
  output logic [15:0]   period_cnt
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] high_q, high_d;
  logic [CW-1:0] low_q, low_d;
  logic          pend_vld_q, pend_vld_d;
  logic [CW-1:0] pend_high_q, pend_high_d;
  logic [CW-1:0] pend_low_q, pend_low_d;
  logic          clk_out_q, clk_out_d;
  logic          cfg_err_q, cfg_err_d;

  logic          last_high;
  logic          last_low;
  logic          boundary;
  logic          load;
  logic          cfg_fire;
  logic          cfg_bad;

  // Phase-end detection and config handshake qualifiers; counters compare against length-1 in CW bits.
  always_comb begin
    last_high = (cnt_q == (high_q - CW'(1)));
    last_low  = (cnt_q == (low_q - CW'(1)));
    boundary  = (state_q == ST_LOW) && last_low;
    load      = pend_vld_q && ((state_q == ST_STOP) || boundary);
    cfg_fire  = cfg_valid && !pend_vld_q;
    cfg_bad   = cfg_fire && ((cfg_high == '0) || (cfg_low == '0));
  end

  // Next-state logic: a started period always runs to the end of LOW before en is re-examined.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        if (en) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (last_high) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LOW: begin
        if (last_low) begin
          state_d = en ? ST_HIGH : ST_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase
    clk_out_d = (state_d == ST_HIGH);
  end

  // Pending-ratio register: capture a legal offer, swap it into the active ratio at a boundary.
  always_comb begin
    high_d      = high_q;
    low_d       = low_q;
    pend_vld_d  = pend_vld_q;
    pend_high_d = pend_high_q;
    pend_low_d  = pend_low_q;
    cfg_err_d   = cfg_bad;
    if (load) begin
      high_d     = pend_high_q;
      low_d      = pend_low_q;
      pend_vld_d = 1'b0;
    end
    if (cfg_fire && !cfg_bad) begin
      pend_high_d = cfg_high;
      pend_low_d  = cfg_low;
      pend_vld_d  = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_STOP;
      cnt_q       <= '0;
      high_q      <= CW'(DEF_HIGH);
      low_q       <= CW'(DEF_LOW);
      pend_vld_q  <= 1'b0;
      pend_high_q <= '0;
      pend_low_q  <= '0;
      clk_out_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_q      <= high_d;
      low_q       <= low_d;
      pend_vld_q  <= pend_vld_d;
      pend_high_q <= pend_high_d;
      pend_low_q  <= pend_low_d;
      clk_out_q   <= clk_out_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign busy        = (state_q != ST_STOP);
  assign period_done = boundary;
  assign cfg_err     = cfg_err_q;
  assign cfg_ready   = !pend_vld_q;

`ifdef CLK_DIV_CTRL_CNT_EN
  logic [15:0] period_cnt_q, period_cnt_d;

  // Completed-period counter, wraps naturally at 16 bits.
  always_comb begin
    period_cnt_d = period_cnt_q;
    if (boundary) period_cnt_d = period_cnt_q + 16'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) period_cnt_q <= 16'd0;
    else        period_cnt_q <= period_cnt_d;
  end

  assign period_cnt = period_cnt_q;
`else
  assign period_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: default ratio, reconfiguration, rejection, stop, reset, period counter.
// Inputs change 1 time unit after posedge; outputs are sampled at the same point.
// Expected sequences are hand-written per scenario.
module tb_clk_div_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_high;
  logic [7:0]  cfg_low;
  logic        clk_out;
  logic        busy;
  logic        period_done;
  logic        cfg_err;
  logic [15:0] period_cnt;

  int n_cmp;
  int n_bad;

  clk_div_ctrl #(.CW(8), .DEF_HIGH(2), .DEF_LOW(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_high   (cfg_high),
    .cfg_low    (cfg_low),
    .clk_out    (clk_out),
    .busy       (busy),
    .period_done(period_done),
    .cfg_err    (cfg_err),
    .period_cnt (period_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    en        = 1'b1;
    cfg_valid = 1'b1;
    cfg_high  = 8'd0;
    cfg_low   = 8'd0;
    tick();
    tick();
    n_cmp++;
    if ({clk_out, busy, period_done, cfg_err, cfg_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_outs: got clk/busy/pd/err/rdy=%b want 00001",
               {clk_out, busy, period_done, cfg_err, cfg_ready});
    end
    n_cmp++;
    if (period_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_pcnt: got %0d want 0", period_cnt);
    end
    cfg_valid = 1'b0;
    en        = 1'b0;
  endtask

  task automatic test_default_ratio();
    logic [2:0] exp;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp = {((i % 3) != 2), ((i % 3) == 2), 1'b1};
      n_cmp++;
      if ({clk_out, period_done, busy} !== exp) begin
        n_bad++;
        $display("FAIL default[%0d]: got clk/pd/busy=%b want %b", i, {clk_out, period_done, busy}, exp);
      end
    end
  endtask

  task automatic test_reconfig();
    logic [0:7] e_clk;
    logic [0:7] e_pd;
    logic [0:7] e_rdy;
    e_clk = 8'b10111000;
    e_pd  = 8'b01000001;
    e_rdy = 8'b00111111;
    do_reset();
    en = 1'b1;
    tick();
    cfg_valid = 1'b1;
    cfg_high  = 8'd3;
    cfg_low   = 8'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      cfg_valid = 1'b0;
      n_cmp++;
      if ({clk_out, period_done, cfg_ready} !== {e_clk[i], e_pd[i], e_rdy[i]}) begin
        n_bad++;
        $display("FAIL reconfig[%0d]: got clk/pd/rdy=%b want %b", i,
                 {clk_out, period_done, cfg_ready}, {e_clk[i], e_pd[i], e_rdy[i]});
      end
    end
  endtask

  task automatic test_cfg_reject();
    logic [0:5] e_clk;
    logic [0:5] e_pd;
    logic [0:5] e_err;
    e_clk = 6'b101101;
    e_pd  = 6'b010010;
    e_err = 6'b100000;
    do_reset();
    en = 1'b1;
    tick();
    cfg_valid = 1'b1;
    cfg_high  = 8'd0;
    cfg_low   = 8'd4;
    for (int i = 0; i < 6; i++) begin
      tick();
      cfg_valid = 1'b0;
      n_cmp++;
      if ({clk_out, period_done, cfg_err, cfg_ready} !== {e_clk[i], e_pd[i], e_err[i], 1'b1}) begin
        n_bad++;
        $display("FAIL reject_h0[%0d]: got clk/pd/err/rdy=%b want %b", i,
                 {clk_out, period_done, cfg_err, cfg_ready}, {e_clk[i], e_pd[i], e_err[i], 1'b1});
      end
    end
    cfg_valid = 1'b1;
    cfg_high  = 8'd5;
    cfg_low   = 8'd0;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if ({cfg_err, cfg_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL reject_l0: got err/rdy=%b want 11", {cfg_err, cfg_ready});
    end
    tick();
    n_cmp++;
    if ({cfg_err, cfg_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL reject_l0_clear: got err/rdy=%b want 01", {cfg_err, cfg_ready});
    end
  endtask

  task automatic test_stop_mid_period();
    logic [0:6] e_clk;
    logic [0:6] e_pd;
    logic [0:6] e_busy;
    e_clk  = 7'b1100000;
    e_pd   = 7'b0000100;
    e_busy = 7'b1111100;
    do_reset();
    cfg_valid = 1'b1;
    cfg_high  = 8'd3;
    cfg_low   = 8'd3;
    tick();
    n_cmp++;
    if ({cfg_ready, busy, clk_out} !== 3'b000) begin
      n_bad++;
      $display("FAIL stop_accept: got rdy/busy/clk=%b want 000", {cfg_ready, busy, clk_out});
    end
    cfg_high = 8'd5;
    cfg_low  = 8'd5;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_load_rdy: got %b want 1", cfg_ready);
    end
    en = 1'b1;
    tick();
    n_cmp++;
    if ({clk_out, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL stop_start: got clk/busy=%b want 11", {clk_out, busy});
    end
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if ({clk_out, period_done, busy} !== {e_clk[i], e_pd[i], e_busy[i]}) begin
        n_bad++;
        $display("FAIL stop_drain[%0d]: got clk/pd/busy=%b want %b", i,
                 {clk_out, period_done, busy}, {e_clk[i], e_pd[i], e_busy[i]});
      end
    end
  endtask

  task automatic test_reset_mid_low();
    logic [0:5] e_clk;
    logic [0:5] e_pd;
    e_clk = 6'b110110;
    e_pd  = 6'b001001;
    do_reset();
    cfg_valid = 1'b1;
    cfg_high  = 8'd2;
    cfg_low   = 8'd3;
    tick();
    cfg_valid = 1'b0;
    tick();
    en = 1'b1;
    tick();
    tick();
    cfg_valid = 1'b1;
    cfg_high  = 8'd4;
    cfg_low   = 8'd4;
    tick();
    cfg_valid = 1'b0;
    tick();
    n_cmp++;
    if ({clk_out, period_done, cfg_ready, busy} !== 4'b0001) begin
      n_bad++;
      $display("FAIL rst_low_pre: got clk/pd/rdy/busy=%b want 0001", {clk_out, period_done, cfg_ready, busy});
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({clk_out, busy, cfg_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL rst_low_post: got clk/busy/rdy=%b want 001", {clk_out, busy, cfg_ready});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({clk_out, period_done, cfg_ready} !== {e_clk[i], e_pd[i], 1'b1}) begin
        n_bad++;
        $display("FAIL rst_low_run[%0d]: got clk/pd/rdy=%b want %b", i,
                 {clk_out, period_done, cfg_ready}, {e_clk[i], e_pd[i], 1'b1});
      end
    end
  endtask

  task automatic test_period_cnt();
    int pc_model;
    pc_model = 0;
    do_reset();
    cfg_valid = 1'b1;
    cfg_high  = 8'd1;
    cfg_low   = 8'd1;
    tick();
    cfg_valid = 1'b0;
    tick();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({clk_out, period_done} !== {((i % 2) == 0), ((i % 2) == 1)}) begin
        n_bad++;
        $display("FAIL div2[%0d]: got clk/pd=%b want %b", i, {clk_out, period_done},
                 {((i % 2) == 0), ((i % 2) == 1)});
      end
      n_cmp++;
      if (period_cnt !== 16'(pc_model)) begin
        n_bad++;
        $display("FAIL pcnt[%0d]: got %0d want %0d", i, period_cnt, pc_model);
      end
`ifdef CLK_DIV_CTRL_CNT_EN
      if ((i % 2) == 1) pc_model++;
`endif
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (period_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL pcnt_reset: got %0d want 0", period_cnt);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_high  = 8'd0;
    cfg_low   = 8'd0;
    test_reset();
    test_default_ratio();
    test_reconfig();
    test_cfg_reject();
    test_stop_mid_period();
    test_reset_mid_low();
    test_period_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
